// File: rtl/link_frame_scheduler_if.sv
// Link frame scheduler handshake bundle: sender sync/enable/ready inputs
// and the per-phase enables, sample index and frame status returned to the datapath.
interface link_frame_scheduler_if;
    logic        sync_in;
    logic        enable;
    logic        sample_ready;
    logic        ready;
    logic        preamble_en;
    logic        payload_en;
    logic        guard_en;
    logic [7:0]  sample_idx;
    logic        sync_out;
    logic [15:0] frame_cnt;
    logic        abort;

    modport master (
        output sync_in, enable, sample_ready,
        input  ready, preamble_en, payload_en, guard_en, sample_idx, sync_out, frame_cnt, abort
    );

    modport slave (
        input  sync_in, enable, sample_ready,
        output ready, preamble_en, payload_en, guard_en, sample_idx, sync_out, frame_cnt, abort
    );
endinterface

// File: rtl/link_frame_scheduler.sv
// Frame sequencer for the link datapath: warm-up, then sync-armed preamble/payload/guard frames.
// Optional payload stall abort is built when LFS_STALL_ABORT_EN is defined.
module link_frame_scheduler #(
    parameter int WARMUP_CYCLES = 720,
    parameter int PREAMBLE_LEN  = 16,
    parameter int PAYLOAD_LEN   = 64,
    parameter int GUARD_LEN     = 8,
    parameter int STALL_MAX     = 32
) (
    input  logic                        clock,
    input  logic                        resetN,
    link_frame_scheduler_if.slave       lnk
);

    // One counter serves warm-up, preamble, guard and (optionally) payload stall timing.
    localparam int CNT_W = $clog2(WARMUP_CYCLES + PREAMBLE_LEN + GUARD_LEN + STALL_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_ZERO      = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE       = CNT_W'(1);
    localparam logic [CNT_W-1:0] WARMUP_LAST   = CNT_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] PREAMBLE_LAST = CNT_W'(PREAMBLE_LEN - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST    = CNT_W'(GUARD_LEN - 1);
    localparam logic [7:0]       IDX_LAST      = 8'(PAYLOAD_LEN - 1);
`ifdef LFS_STALL_ABORT_EN
    localparam logic [CNT_W-1:0] STALL_LAST    = CNT_W'(STALL_MAX - 1);
`endif

    typedef enum logic [2:0] {
        ST_WARMUP   = 3'd0,
        ST_IDLE     = 3'd1,
        ST_PREAMBLE = 3'd2,
        ST_PAYLOAD  = 3'd3,
        ST_GUARD    = 3'd4
    } state_t;

    state_t            state_r, state_nxt;
    logic [CNT_W-1:0]  cnt_r, cnt_nxt;
    logic [7:0]        idx_r, idx_nxt;
    logic [15:0]       frame_r, frame_nxt;
    logic              ready_r, ready_nxt;
    logic              preamble_r, preamble_nxt;
    logic              payload_r, payload_nxt;
    logic              guard_r, guard_nxt;
    logic              sync_out_r, sync_out_nxt;
    logic              s1_r, s2_r, s3_r;
    logic              sync_edge_s;
    logic              fire_s;
`ifdef LFS_STALL_ABORT_EN
    logic              abort_r, abort_nxt;
    logic              aborted_r, aborted_nxt;
`endif

    assign sync_edge_s = s2_r & ~s3_r;
    assign fire_s      = payload_r & lnk.sample_ready;

    // Sync input synchroniser and edge-history chain.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= lnk.sync_in;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    // Next-state and next-output logic; phase enables follow the next state so they come out registered.
    always_comb begin
        state_nxt    = state_r;
        cnt_nxt      = cnt_r;
        idx_nxt      = idx_r;
        frame_nxt    = frame_r;
        ready_nxt    = ready_r;
        sync_out_nxt = 1'b0;
`ifdef LFS_STALL_ABORT_EN
        abort_nxt    = 1'b0;
        aborted_nxt  = aborted_r;
`endif
        case (state_r)
            ST_WARMUP: begin
                if (cnt_r == WARMUP_LAST) begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = CNT_ZERO;
                    ready_nxt = 1'b1;
                end else begin
                    cnt_nxt   = cnt_r + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (sync_edge_s) begin
                    state_nxt    = ST_PREAMBLE;
                    cnt_nxt      = CNT_ZERO;
                    sync_out_nxt = 1'b1;
                end else begin
                    state_nxt    = ST_IDLE;
                end
            end
            ST_PREAMBLE: begin
                if (cnt_r == PREAMBLE_LAST) begin
                    state_nxt = ST_PAYLOAD;
                    cnt_nxt   = CNT_ZERO;
                    idx_nxt   = 8'd0;
                end else begin
                    cnt_nxt   = cnt_r + CNT_ONE;
                end
            end
            ST_PAYLOAD: begin
                if (fire_s) begin
                    cnt_nxt = CNT_ZERO;
                    if (idx_r == IDX_LAST) begin
                        state_nxt = ST_GUARD;
                        idx_nxt   = 8'd0;
                    end else begin
                        idx_nxt   = idx_r + 8'd1;
                    end
                end else begin
`ifdef LFS_STALL_ABORT_EN
                    // cnt_r counts consecutive stalled payload cycles here.
                    if (cnt_r == STALL_LAST) begin
                        state_nxt   = ST_GUARD;
                        cnt_nxt     = CNT_ZERO;
                        idx_nxt     = 8'd0;
                        abort_nxt   = 1'b1;
                        aborted_nxt = 1'b1;
                    end else begin
                        cnt_nxt     = cnt_r + CNT_ONE;
                    end
`else
                    idx_nxt = idx_r;
`endif
                end
            end
            ST_GUARD: begin
                if (cnt_r == GUARD_LAST) begin
                    cnt_nxt = CNT_ZERO;
`ifdef LFS_STALL_ABORT_EN
                    if (aborted_r) begin
                        frame_nxt = frame_r;
                    end else begin
                        frame_nxt = frame_r + 16'd1;
                    end
                    aborted_nxt = 1'b0;
`else
                    frame_nxt = frame_r + 16'd1;
`endif
                    if (lnk.enable) begin
                        state_nxt    = ST_PREAMBLE;
                        sync_out_nxt = 1'b1;
                    end else begin
                        state_nxt    = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_nxt = ST_WARMUP;
                cnt_nxt   = CNT_ZERO;
                idx_nxt   = 8'd0;
                frame_nxt = 16'd0;
                ready_nxt = 1'b0;
            end
        endcase
        preamble_nxt = (state_nxt == ST_PREAMBLE);
        payload_nxt  = (state_nxt == ST_PAYLOAD);
        guard_nxt    = (state_nxt == ST_GUARD);
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state_r    <= ST_WARMUP;
            cnt_r      <= CNT_ZERO;
            idx_r      <= 8'd0;
            frame_r    <= 16'd0;
            ready_r    <= 1'b0;
            preamble_r <= 1'b0;
            payload_r  <= 1'b0;
            guard_r    <= 1'b0;
            sync_out_r <= 1'b0;
`ifdef LFS_STALL_ABORT_EN
            abort_r    <= 1'b0;
            aborted_r  <= 1'b0;
`endif
        end else begin
            state_r    <= state_nxt;
            cnt_r      <= cnt_nxt;
            idx_r      <= idx_nxt;
            frame_r    <= frame_nxt;
            ready_r    <= ready_nxt;
            preamble_r <= preamble_nxt;
            payload_r  <= payload_nxt;
            guard_r    <= guard_nxt;
            sync_out_r <= sync_out_nxt;
`ifdef LFS_STALL_ABORT_EN
            abort_r    <= abort_nxt;
            aborted_r  <= aborted_nxt;
`endif
        end
    end

    assign lnk.ready       = ready_r;
    assign lnk.preamble_en = preamble_r;
    assign lnk.payload_en  = payload_r;
    assign lnk.guard_en    = guard_r;
    assign lnk.sample_idx  = idx_r;
    assign lnk.sync_out    = sync_out_r;
    assign lnk.frame_cnt   = frame_r;
`ifdef LFS_STALL_ABORT_EN
    assign lnk.abort       = abort_r;
`else
    assign lnk.abort       = 1'b0;
`endif

endmodule
